// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit adder that processes DIGIT bits per clock through
// a registered carry, taking WIDTH/DIGIT cycles per add (start/busy/done).
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow port ovf.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_adder: DIGIT must be non-zero and divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DIGIT:0]   slice_sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Next-state: capture on accepted start, one slice per RUN cycle, publish
  // the result only on the final slice.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    slice_sum = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]}
              + (DIGIT+1)'(carry_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        // New slice enters at the MSB end; after N slices the LSB slice has
        // been pushed down to bit 0.
        acc_d   = WIDTH'({slice_sum[DIGIT-1:0], acc_q} >> DIGIT);
        carry_d = slice_sum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = acc_d;
          cout_d  = slice_sum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
          // Final slice holds the operand MSBs at bit DIGIT-1.
          ovf_d   = (a_sh_q[DIGIT-1] == b_sh_q[DIGIT-1]) &&
                    (slice_sum[DIGIT-1] != a_sh_q[DIGIT-1]);
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: instance A (WIDTH=8, DIGIT=1) and
// instance B (WIDTH=16, DIGIT=4) driven by random and directed stimulus.
module tb_serial_adder;

  localparam int NA = 8;
  localparam int NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    time         t;
  } exp_t;

  int checks = 0;
  int errors = 0;

  // Instance A signals
  logic        rst_a = 1'b1, start_a = 1'b0, cin_a = 1'b0;
  logic [7:0]  a_a = '0, b_a = '0;
  logic        busy_a, done_a, cout_a;
  logic [7:0]  sum_a;
  // Instance B signals
  logic        rst_b = 1'b1, start_b = 1'b0, cin_b = 1'b0;
  logic [15:0] a_b = '0, b_b = '0;
  logic        busy_b, done_b, cout_b;
  logic [15:0] sum_b;
`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf_a, ovf_b;
`endif

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut_a (
    .clk   (clk),
    .rst   (rst_a),
    .start (start_a),
    .a     (a_a),
    .b     (b_a),
    .cin   (cin_a),
    .busy  (busy_a),
    .done  (done_a),
    .sum   (sum_a),
    .cout  (cout_a)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf_a)
`endif
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut_b (
    .clk   (clk),
    .rst   (rst_b),
    .start (start_b),
    .a     (a_b),
    .b     (b_b),
    .cin   (cin_b),
    .busy  (busy_b),
    .done  (done_b),
    .sum   (sum_b),
    .cout  (cout_b)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf_b)
`endif
  );

  // Model state: scoreboards, in-flight cycles left, held outputs, busy.
  exp_t q_a[$], q_b[$];
  exp_t pend_a, pend_b, hold_a, hold_b;
  int   wait_a = 0, wait_b = 0;
  logic busy_exp_a = 1'b0, busy_exp_b = 1'b0;
  logic mon_en_a = 1'b0, mon_en_b = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                 input logic c, input time t);
    exp_t    e;
    longint  full, half, sx, sy, s;
    half   = longint'(1) << (w - 1);
    full   = longint'(x) + longint'(y) + longint'(c);
    e.sum  = 16'(full & ((longint'(1) << w) - 1));
    e.cout = ((full >> w) & 1) != 0;
    sx     = (longint'(x) >= half) ? longint'(x) - 2 * half : longint'(x);
    sy     = (longint'(y) >= half) ? longint'(y) - 2 * half : longint'(y);
    s      = sx + sy + longint'(c);
    e.ovf  = (s < -half) || (s >= half);
    e.t    = t;
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.sum = '0; e.cout = 1'b0; e.ovf = 1'b0; e.t = 0;
    return e;
  endfunction

  task automatic step_a(input logic st, input logic r, input logic [7:0] x,
                        input logic [7:0] y, input logic c);
    rst_a = r; start_a = st; a_a = x; b_a = y; cin_a = c;
    @(posedge clk);
    if (r) begin
      wait_a = 0; q_a.delete(); hold_a = zero_exp();
    end else if (wait_a == 0 && st) begin
      pend_a = model(8, {8'h00, x}, {8'h00, y}, c, $time + NA * 10);
      q_a.push_back(pend_a);
      wait_a = NA;
    end else if (wait_a > 0) begin
      wait_a--;
      if (wait_a == 0) hold_a = pend_a;
    end
    busy_exp_a = (wait_a > 0);
    #1;
  endtask

  task automatic step_b(input logic st, input logic r, input logic [15:0] x,
                        input logic [15:0] y, input logic c);
    rst_b = r; start_b = st; a_b = x; b_b = y; cin_b = c;
    @(posedge clk);
    if (r) begin
      wait_b = 0; q_b.delete(); hold_b = zero_exp();
    end else if (wait_b == 0 && st) begin
      pend_b = model(16, x, y, c, $time + NB * 10);
      q_b.push_back(pend_b);
      wait_b = NB;
    end else if (wait_b > 0) begin
      wait_b--;
      if (wait_b == 0) hold_b = pend_b;
    end
    busy_exp_b = (wait_b > 0);
    #1;
  endtask

  task automatic idle_a(input int n);
    repeat (n) step_a(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic idle_b(input int n);
    repeat (n) step_b(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  task automatic prog_a();
    logic [7:0] va[8] = '{8'h5A, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h40, 8'h00, 8'hAA};
    logic [7:0] vb[8] = '{8'h3C, 8'h01, 8'hFF, 8'h01, 8'h80, 8'h10, 8'h00, 8'h55};
    logic       vc[8] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
    step_a(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    step_a(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    mon_en_a = 1'b1;
    idle_a(2);
    for (int i = 0; i < 8; i++) begin
      step_a(1'b1, 1'b0, va[i], vb[i], vc[i]);
      idle_a(9);
    end
    // start re-asserted with zero operands mid-operation
    step_a(1'b1, 1'b0, 8'hC3, 8'h21, 1'b1);
    idle_a(2);
    step_a(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    idle_a(8);
    // reset during the third RUN cycle, then a fresh add
    step_a(1'b1, 1'b0, 8'h9D, 8'h47, 1'b0);
    idle_a(2);
    step_a(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    idle_a(3);
    step_a(1'b1, 1'b0, 8'h21, 8'h35, 1'b1);
    idle_a(9);
    for (int i = 0; i < 300; i++)
      step_a(1'($urandom_range(3) == 0), 1'($urandom_range(80) == 0),
             8'($urandom), 8'($urandom), 1'($urandom));
    step_a(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    idle_a(12);
  endtask

  task automatic prog_b();
    step_b(1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
    step_b(1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
    mon_en_b = 1'b1;
    idle_b(2);
    step_b(1'b1, 1'b0, 16'h1234, 16'hEDCC, 1'b0);
    idle_b(6);
    step_b(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
    idle_b(6);
    // start held high: back-to-back adds
    repeat (25) step_b(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    idle_b(6);
    for (int i = 0; i < 300; i++)
      step_b(1'($urandom_range(2) == 0), 1'($urandom_range(80) == 0),
             16'($urandom), 16'($urandom), 1'($urandom));
    step_b(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    idle_b(12);
  endtask

  // Monitor A: pops the scoreboard on each expected done, else checks hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en_a) begin
        check("busy_a", 64'(busy_a), 64'(busy_exp_a));
        if (q_a.size() > 0 && q_a[0].t == $time - 5) begin
          e = q_a.pop_front();
          check("done_a", 64'(done_a), 64'(1'b1));
          check("sum_a", 64'(sum_a), 64'(e.sum));
          check("cout_a", 64'(cout_a), 64'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
          check("ovf_a", 64'(ovf_a), 64'(e.ovf));
`endif
        end else begin
          check("no_done_a", 64'(done_a), 64'(1'b0));
          check("hold_sum_a", 64'(sum_a), 64'(hold_a.sum));
          check("hold_cout_a", 64'(cout_a), 64'(hold_a.cout));
`ifdef SERIAL_ADDER_OVF_EN
          check("hold_ovf_a", 64'(ovf_a), 64'(hold_a.ovf));
`endif
        end
      end
    end
  end

  // Monitor B
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en_b) begin
        check("busy_b", 64'(busy_b), 64'(busy_exp_b));
        if (q_b.size() > 0 && q_b[0].t == $time - 5) begin
          e = q_b.pop_front();
          check("done_b", 64'(done_b), 64'(1'b1));
          check("sum_b", 64'(sum_b), 64'(e.sum));
          check("cout_b", 64'(cout_b), 64'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
          check("ovf_b", 64'(ovf_b), 64'(e.ovf));
`endif
        end else begin
          check("no_done_b", 64'(done_b), 64'(1'b0));
          check("hold_sum_b", 64'(sum_b), 64'(hold_b.sum));
          check("hold_cout_b", 64'(cout_b), 64'(hold_b.cout));
`ifdef SERIAL_ADDER_OVF_EN
          check("hold_ovf_b", 64'(ovf_b), 64'(hold_b.ovf));
`endif
        end
      end
    end
  end

  initial begin
    hold_a = zero_exp();
    hold_b = zero_exp();
    pend_a = zero_exp();
    pend_b = zero_exp();
    fork
      prog_a();
      prog_b();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

endmodule
